// File: rtl/ov7670_pixel_source.sv
// OV7670-style DVP transmitter: vsync/href/D_data frames in RGB444 from a built-in pattern generator.
// Optional per-frame CRC-16-CCITT output is enabled with `define OV7670_SRC_CRC_EN.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | outputs low, waiting for enable
// ST_VSYNC  | vsync high for VSYNC_LINES lines
// ST_VBACK  | blank lines between vsync and first active line
// ST_ACTIVE | V_ACTIVE lines, href high for the first 2*H_ACTIVE bytes
// ST_VFRONT | blank lines after the last active line; frame_done on its last cycle
module ov7670_pixel_source #(
  parameter int H_ACTIVE      = 320,
  parameter int V_ACTIVE      = 240,
  parameter int H_BLANK       = 144,
  parameter int VSYNC_LINES   = 3,
  parameter int V_BACK_LINES  = 17,
  parameter int V_FRONT_LINES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] solid_rgb,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  D_data,
  output logic        frame_start,
  output logic        frame_done,
  output logic [15:0] frame_count
`ifdef OV7670_SRC_CRC_EN
  ,
  output logic [15:0] frame_crc
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_t;

  localparam logic [15:0] ACT_BYTES = 16'(2 * H_ACTIVE);
  localparam logic [15:0] LINE_LAST = 16'(2 * H_ACTIVE + H_BLANK - 1);
  localparam logic [15:0] BAR_LAST  = 16'(H_ACTIVE / 8 - 1);
  localparam logic [15:0] VS_LAST   = 16'(VSYNC_LINES - 1);
  localparam logic [15:0] VB_LAST   = 16'(V_BACK_LINES - 1);
  localparam logic [15:0] VA_LAST   = 16'(V_ACTIVE - 1);
  localparam logic [15:0] VF_LAST   = 16'(V_FRONT_LINES - 1);

  state_t      state, nxt_state;
  logic [15:0] col, nxt_col;
  logic [15:0] line, nxt_line, last_line;
  logic [15:0] bar_px, nxt_bar_px;
  logic [2:0]  bar, nxt_bar;
  logic        start_frame, nxt_done, nxt_href;
  logic [1:0]  pat_q;
  logic [11:0] solid_q;
  logic [11:0] rgb;
  logic [7:0]  px_x;
  logic [3:0]  px_y;
  logic [7:0]  nxt_byte;

  function automatic logic [11:0] bar_rgb(input logic [2:0] b);
    case (b)
      3'd0:    return 12'hFFF;
      3'd1:    return 12'hFF0;
      3'd2:    return 12'h0FF;
      3'd3:    return 12'h0F0;
      3'd4:    return 12'hF0F;
      3'd5:    return 12'hF00;
      3'd6:    return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  always_comb begin
    case (state)
      ST_VSYNC:  last_line = VS_LAST;
      ST_VBACK:  last_line = VB_LAST;
      ST_ACTIVE: last_line = VA_LAST;
      default:   last_line = VF_LAST;
    endcase
  end

  // Next raster position; outputs are registered from it so they line up with the state registers.
  always_comb begin
    nxt_state   = state;
    nxt_col     = col;
    nxt_line    = line;
    start_frame = 1'b0;
    if (state == ST_IDLE) begin
      if (enable) begin
        nxt_state   = ST_VSYNC;
        nxt_col     = '0;
        nxt_line    = '0;
        start_frame = 1'b1;
      end
    end else if (col != LINE_LAST) begin
      nxt_col = col + 16'd1;
    end else begin
      nxt_col = '0;
      if (line != last_line) begin
        nxt_line = line + 16'd1;
      end else begin
        nxt_line = '0;
        case (state)
          ST_VSYNC:  nxt_state = (V_BACK_LINES > 0) ? ST_VBACK : ST_ACTIVE;
          ST_VBACK:  nxt_state = ST_ACTIVE;
          ST_ACTIVE: nxt_state = ST_VFRONT;
          default: begin
            if (enable) begin
              nxt_state   = ST_VSYNC;
              start_frame = 1'b1;
            end else begin
              nxt_state = ST_IDLE;
            end
          end
        endcase
      end
    end
    nxt_done = (nxt_state == ST_VFRONT) && (nxt_col == LINE_LAST) && (nxt_line == VF_LAST);
    nxt_href = (nxt_state == ST_ACTIVE) && (nxt_col < ACT_BYTES);
  end

  // Colour-bar index tracked incrementally to avoid dividing x by H_ACTIVE/8.
  always_comb begin
    nxt_bar    = bar;
    nxt_bar_px = bar_px;
    if (nxt_col == '0) begin
      nxt_bar    = '0;
      nxt_bar_px = '0;
    end else if (!nxt_col[0] && (nxt_col < ACT_BYTES)) begin
      if (bar_px == BAR_LAST) begin
        nxt_bar_px = '0;
        nxt_bar    = bar + 3'd1;
      end else begin
        nxt_bar_px = bar_px + 16'd1;
      end
    end
  end

  always_comb begin
    px_x = nxt_col[8:1];
    px_y = nxt_line[3:0];
    case (pat_q)
      2'd0:    rgb = solid_q;
      2'd1:    rgb = bar_rgb(nxt_bar);
      2'd2:    rgb = {px_x[3:0], px_y, px_x[7:4]};
      default: rgb = (px_x[3] ^ px_y[3] ^ frame_count[0]) ? 12'hFFF : 12'h000;
    endcase
    if (!nxt_href)
      nxt_byte = 8'h00;
    else if (nxt_col[0])
      nxt_byte = rgb[7:0];
    else
      nxt_byte = {4'h0, rgb[11:8]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      col         <= '0;
      line        <= '0;
      bar         <= '0;
      bar_px      <= '0;
      pat_q       <= '0;
      solid_q     <= '0;
      vsync       <= 1'b0;
      href        <= 1'b0;
      D_data      <= 8'h00;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= nxt_state;
      col         <= nxt_col;
      line        <= nxt_line;
      bar         <= nxt_bar;
      bar_px      <= nxt_bar_px;
      if (start_frame) begin
        pat_q   <= pattern_sel;
        solid_q <= solid_rgb;
      end
      vsync       <= (nxt_state == ST_VSYNC);
      href        <= nxt_href;
      D_data      <= nxt_byte;
      frame_start <= start_frame;
      frame_done  <= nxt_done;
      if (nxt_done)
        frame_count <= frame_count + 16'd1;
    end
  end

`ifdef OV7670_SRC_CRC_EN
  logic [15:0] crc_run;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--)
      c = {c[14:0], 1'b0} ^ ((c[15] ^ data[i]) ? 16'h1021 : 16'h0000);
    return c;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_run   <= '0;
      frame_crc <= '0;
    end else begin
      if (frame_start)
        crc_run <= 16'hFFFF;
      else if (href)
        crc_run <= crc16_step(crc_run, D_data);
      if (frame_done)
        frame_crc <= crc_run;
    end
  end
`endif

endmodule

// File: tb/tb_ov7670_pixel_source.sv
// Directed bench for ov7670_pixel_source with a small raster (L=22, frame=154 cycles).
module tb_ov7670_pixel_source;
  localparam int H_ACTIVE = 8, V_ACTIVE = 3, H_BLANK = 6;
  localparam int VSYNC_LINES = 2, V_BACK_LINES = 1, V_FRONT_LINES = 1;
  localparam int FRAME = 154, NCAP = 320;

  logic clk = 1'b0, reset = 1'b1, enable = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic [11:0] solid_rgb = 12'h000;
  logic vsync, href, frame_start, frame_done;
  logic [7:0] D_data;
  logic [15:0] frame_count;
`ifdef OV7670_SRC_CRC_EN
  logic [15:0] frame_crc;
`endif

  int total = 0, bad = 0;
  logic [15:0] exp_fc = 16'd0;
  logic cap_vs [NCAP];
  logic cap_hr [NCAP];
  logic cap_fs [NCAP];
  logic cap_fd [NCAP];
  logic [7:0] cap_d [NCAP];

  ov7670_pixel_source #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
    .VSYNC_LINES(VSYNC_LINES), .V_BACK_LINES(V_BACK_LINES), .V_FRONT_LINES(V_FRONT_LINES)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
    .solid_rgb(solid_rgb), .vsync(vsync), .href(href), .D_data(D_data),
    .frame_start(frame_start), .frame_done(frame_done), .frame_count(frame_count)
`ifdef OV7670_SRC_CRC_EN
    , .frame_crc(frame_crc)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

`ifdef OV7670_SRC_CRC_EN
  function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = (c << 1) ^ 16'h1021;
      else              c = c << 1;
    end
    return c;
  endfunction
`endif

  task automatic wait_start(output int lat);
    lat = -1;
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) lat = i;
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 0; i < 400 && cyc < 0; i++) begin
      if (frame_done === 1'b1) cyc = i;
      else @(negedge clk);
    end
  endtask

  task automatic capture(input int n, input int drop_at, input int chg_at);
    for (int i = 0; i < n; i++) begin
      cap_vs[i] = vsync;
      cap_hr[i] = href;
      cap_fs[i] = frame_start;
      cap_fd[i] = frame_done;
      cap_d[i]  = D_data;
      if (i == drop_at) enable = 1'b0;
      if (i == chg_at) pattern_sel = 2'd2;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if ({vsync, href, frame_start, frame_done} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 0000", {vsync, href, frame_start, frame_done});
    end
    total++;
    if (D_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", D_data); end
    total++;
    if (frame_count !== 16'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", frame_count); end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (vsync !== 1'b0) begin bad++; $display("FAIL idle_vsync: got %b want 0", vsync); end
  endtask

  task automatic test_timing;
    int lat, nv, fr, nfd, nfs, rel;
    logic eh;
    logic [7:0] ed;
    pattern_sel = 2'd0;
    solid_rgb = 12'hA5C;
    enable = 1'b1;
    wait_start(lat);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL start_latency: got %0d want 1", lat); end
    capture(FRAME + 2, 0, -1);
    exp_fc = exp_fc + 16'd1;
    nv = 0; fr = -1; nfd = 0; nfs = 0;
    for (int i = 0; i < FRAME + 2; i++) begin
      if (i < FRAME && cap_vs[i]) nv++;
      if (cap_hr[i] && fr < 0) fr = i;
      if (cap_fd[i]) nfd++;
      if (cap_fs[i]) nfs++;
    end
    total++;
    if (nv !== 44) begin bad++; $display("FAIL vsync_len: got %0d want 44", nv); end
    total++;
    if ({cap_vs[0], cap_vs[43], cap_vs[44]} !== 3'b110) begin
      bad++; $display("FAIL vsync_edges: got %b want 110", {cap_vs[0], cap_vs[43], cap_vs[44]});
    end
    total++;
    if (fr !== 66) begin bad++; $display("FAIL href_first_rise: got %0d want 66", fr); end
    for (int i = 0; i < FRAME; i++) begin
      rel = i - 66;
      eh = (i >= 66) && (i < 132) && ((rel % 22) < 16);
      ed = eh ? (((rel % 2) == 0) ? 8'h0A : 8'h5C) : 8'h00;
      total++;
      if (cap_hr[i] !== eh) begin bad++; $display("FAIL href_c%0d: got %b want %b", i, cap_hr[i], eh); end
      total++;
      if (cap_d[i] !== ed) begin bad++; $display("FAIL solid_c%0d: got %h want %h", i, cap_d[i], ed); end
    end
    total++;
    if (cap_fd[153] !== 1'b1 || nfd !== 1) begin
      bad++; $display("FAIL frame_done_pos: got fd153=%b count=%0d want 1/1", cap_fd[153], nfd);
    end
    total++;
    if (nfs !== 1) begin bad++; $display("FAIL frame_start_count: got %0d want 1", nfs); end
    total++;
    if (frame_count !== exp_fc) begin bad++; $display("FAIL frame_count_1: got %0d want %0d", frame_count, exp_fc); end
    total++;
    if ({cap_vs[154], cap_vs[155]} !== 2'b00) begin
      bad++; $display("FAIL idle_after_stop: got %b want 00", {cap_vs[154], cap_vs[155]});
    end
  endtask

  task automatic test_colour_bars;
    int lat;
    logic [7:0] exp_b [16];
    exp_b = '{8'h0F, 8'hFF, 8'h0F, 8'hF0, 8'h00, 8'hFF, 8'h00, 8'hF0,
              8'h0F, 8'h0F, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00};
    pattern_sel = 2'd1;
    enable = 1'b1;
    wait_start(lat);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL bars_start_latency: got %0d want 1", lat); end
    // pattern_sel flips to gradient during vsync; this frame must still show bars
    capture(FRAME + 1, 0, 10);
    exp_fc = exp_fc + 16'd1;
    for (int k = 0; k < 16; k++) begin
      total++;
      if (cap_d[66 + k] !== exp_b[k]) begin
        bad++; $display("FAIL bars_l0_b%0d: got %h want %h", k, cap_d[66 + k], exp_b[k]);
      end
      total++;
      if (cap_d[110 + k] !== exp_b[k]) begin
        bad++; $display("FAIL bars_l2_b%0d: got %h want %h", k, cap_d[110 + k], exp_b[k]);
      end
    end
  endtask

  task automatic test_gradient;
    int lat;
    logic [7:0] ev;
    enable = 1'b1;
    wait_start(lat);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL grad_start_latency: got %0d want 1", lat); end
    capture(FRAME + 1, 0, -1);
    exp_fc = exp_fc + 16'd1;
    for (int y = 0; y < 3; y++) begin
      for (int k = 0; k < 16; k++) begin
        ev = ((k % 2) == 0) ? 8'(k / 2) : 8'(y << 4);
        total++;
        if (cap_d[66 + 22 * y + k] !== ev) begin
          bad++; $display("FAIL grad_y%0d_b%0d: got %h want %h", y, k, cap_d[66 + 22 * y + k], ev);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [15:0] fc0, fc1;
    logic [7:0] e0_even, e0_odd, e1_even, e1_odd;
    fc0 = exp_fc;
    fc1 = exp_fc + 16'd1;
    e0_even = fc0[0] ? 8'h0F : 8'h00;
    e0_odd  = fc0[0] ? 8'hFF : 8'h00;
    e1_even = fc1[0] ? 8'h0F : 8'h00;
    e1_odd  = fc1[0] ? 8'hFF : 8'h00;
    pattern_sel = 2'd3;
    enable = 1'b1;
    wait_start(lat);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL b2b_start_latency: got %0d want 1", lat); end
    capture(2 * FRAME + 5, FRAME + 50, -1);
    exp_fc = exp_fc + 16'd2;
    total++;
    if ({cap_fd[153], cap_fs[154], cap_vs[154]} !== 3'b111) begin
      bad++; $display("FAIL b2b_restart: got %b want 111", {cap_fd[153], cap_fs[154], cap_vs[154]});
    end
    total++;
    if ({cap_d[66], cap_d[67]} !== {e0_even, e0_odd}) begin
      bad++; $display("FAIL checker_f0: got %h want %h", {cap_d[66], cap_d[67]}, {e0_even, e0_odd});
    end
    total++;
    if ({cap_d[124], cap_d[125]} !== {e0_even, e0_odd}) begin
      bad++; $display("FAIL checker_f0_last: got %h want %h", {cap_d[124], cap_d[125]}, {e0_even, e0_odd});
    end
    total++;
    if ({cap_d[FRAME + 66], cap_d[FRAME + 67]} !== {e1_even, e1_odd}) begin
      bad++; $display("FAIL checker_f1: got %h want %h", {cap_d[FRAME + 66], cap_d[FRAME + 67]}, {e1_even, e1_odd});
    end
    total++;
    if (cap_fd[2 * FRAME - 1] !== 1'b1) begin bad++; $display("FAIL stop_frame_done: got %b want 1", cap_fd[2 * FRAME - 1]); end
    for (int i = 2 * FRAME; i < 2 * FRAME + 5; i++) begin
      total++;
      if ({cap_vs[i], cap_hr[i], cap_fs[i], cap_fd[i], cap_d[i]} !== 12'h000) begin
        bad++; $display("FAIL stop_idle_c%0d: got %h want 000", i, {cap_vs[i], cap_hr[i], cap_fs[i], cap_fd[i], cap_d[i]});
      end
    end
    total++;
    if (frame_count !== exp_fc) begin bad++; $display("FAIL b2b_count: got %0d want %0d", frame_count, exp_fc); end
  endtask

  task automatic test_async_reset;
    int lat, cyc;
    pattern_sel = 2'd0;
    solid_rgb = 12'hA5C;
    enable = 1'b1;
    wait_start(lat);
    repeat (70) @(negedge clk);
    total++;
    if ({href, D_data} !== {1'b1, 8'h0A}) begin
      bad++; $display("FAIL pre_reset_active: got %b/%h want 1/0a", href, D_data);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({vsync, href, frame_start, frame_done} !== 4'b0000 || D_data !== 8'h00) begin
      bad++; $display("FAIL async_reset_out: got %b/%h want 0000/00", {vsync, href, frame_start, frame_done}, D_data);
    end
    total++;
    if (frame_count !== 16'd0) begin bad++; $display("FAIL async_reset_count: got %0d want 0", frame_count); end
`ifdef OV7670_SRC_CRC_EN
    total++;
    if (frame_crc !== 16'h0000) begin bad++; $display("FAIL async_reset_crc: got %h want 0000", frame_crc); end
`endif
    exp_fc = 16'd0;
    @(negedge clk);
    solid_rgb = 12'h000;
    reset = 1'b0;
    wait_start(lat);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL post_reset_latency: got %0d want 1", lat); end
    enable = 1'b0;
    wait_done(cyc);
    total++;
    if (cyc !== 153) begin bad++; $display("FAIL post_reset_done: got %0d want 153", cyc); end
    exp_fc = exp_fc + 16'd1;
    @(negedge clk);
    total++;
    if (frame_count !== exp_fc) begin bad++; $display("FAIL post_reset_count: got %0d want %0d", frame_count, exp_fc); end
  endtask

`ifdef OV7670_SRC_CRC_EN
  task automatic test_crc;
    int lat, cyc;
    logic [15:0] crc_zero, crc_a5c;
    crc_zero = 16'hFFFF;
    crc_a5c = 16'hFFFF;
    for (int i = 0; i < 24; i++) begin
      crc_zero = crc_byte(crc_byte(crc_zero, 8'h00), 8'h00);
      crc_a5c  = crc_byte(crc_byte(crc_a5c, 8'h0A), 8'h5C);
    end
    total++;
    if (frame_crc !== crc_zero) begin bad++; $display("FAIL crc_zero: got %h want %h", frame_crc, crc_zero); end
    solid_rgb = 12'hA5C;
    enable = 1'b1;
    wait_start(lat);
    enable = 1'b0;
    repeat (100) @(negedge clk);
    total++;
    if (frame_crc !== crc_zero) begin bad++; $display("FAIL crc_hold: got %h want %h", frame_crc, crc_zero); end
    wait_done(cyc);
    @(negedge clk);
    total++;
    if (frame_crc !== crc_a5c) begin bad++; $display("FAIL crc_a5c: got %h want %h", frame_crc, crc_a5c); end
  endtask
`endif

  initial begin
    test_reset;
    test_timing;
    test_colour_bars;
    test_gradient;
    test_back_to_back;
    test_async_reset;
`ifdef OV7670_SRC_CRC_EN
    test_crc;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
